// File: rtl/mmio_port_bank.sv
// mmio_port_bank: NUM_CH memory-mapped switch/LED channels at BASE_ADDR+i,
// with a write-1-to-clear change-flag register at BASE_ADDR+NUM_CH.
// Optional debounce stage enabled by defining MMIO_DEBOUNCE_EN; the default
// build feeds the second synchroniser stage straight to the read path.
module mmio_port_bank #(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned WIDTH     = 16,
  parameter logic [15:0] BASE_ADDR = 16'h2000,
  parameter int unsigned DEB_CYC   = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [15:0]             memAddr,
  input  logic                    re_L,
  input  logic                    we_L,
  input  logic [15:0]             wrData,
  output logic [15:0]             rdData,
  output logic                    drive_L,
  input  logic [NUM_CH*WIDTH-1:0] swIn,
  output logic [NUM_CH*WIDTH-1:0] ledOut,
  output logic                    chgIrq
);

  localparam int unsigned BUS_W = NUM_CH * WIDTH;

  logic [15:0]       offset;
  logic              hit_ch;
  logic              hit_flag;
  logic              rd_en;
  logic              wr_en;

  logic [BUS_W-1:0]  s1_q;
  logic [BUS_W-1:0]  s2_q;
  logic [BUS_W-1:0]  led_q;
  logic [BUS_W-1:0]  led_d;
  logic [NUM_CH-1:0] flag_q;
  logic [NUM_CH-1:0] flag_d;

  // Debounced value visible to reads, and the value it takes after this edge.
  logic [BUS_W-1:0]  deb_cur;
  logic [BUS_W-1:0]  deb_nxt;

  // Address decode relative to the bank base.
  always_comb begin
    offset   = memAddr - BASE_ADDR;
    hit_ch   = (offset < 16'(NUM_CH));
    hit_flag = (offset == 16'(NUM_CH));
    rd_en    = !re_L && (hit_ch || hit_flag);
    wr_en    = !we_L && (hit_ch || hit_flag);
  end

`ifdef MMIO_DEBOUNCE_EN
  localparam int unsigned CNT_W = (DEB_CYC + 1 > 1) ? $clog2(DEB_CYC + 1) : 1;

  logic [BUS_W-1:0] deb_q;
  logic [BUS_W-1:0] deb_d;
  logic [CNT_W-1:0] cnt_q [NUM_CH];
  logic [CNT_W-1:0] cnt_d [NUM_CH];

  // Per-channel stability counter: deb follows s2 only after DEB_CYC steady edges.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      cnt_d[i] = cnt_q[i];
      if (s2_q[i*WIDTH +: WIDTH] == deb_q[i*WIDTH +: WIDTH]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_W'(DEB_CYC - 1)) begin
        deb_d[i*WIDTH +: WIDTH] = s2_q[i*WIDTH +: WIDTH];
        cnt_d[i]                = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      deb_q <= '0;
      for (int i = 0; i < int'(NUM_CH); i++) cnt_q[i] <= '0;
    end else begin
      deb_q <= deb_d;
      for (int i = 0; i < int'(NUM_CH); i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign deb_cur = deb_q;
  assign deb_nxt = deb_d;
`else
  // Without debounce the synchroniser output is the debounced value.
  assign deb_cur = s2_q;
  assign deb_nxt = s1_q;
`endif

  // LED loads and sticky change flags; a new change beats a same-cycle clear.
  always_comb begin
    led_d  = led_q;
    flag_d = flag_q;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (wr_en && (offset == 16'(i))) begin
        led_d[i*WIDTH +: WIDTH] = wrData[WIDTH-1:0];
      end
      if (wr_en && hit_flag && wrData[i]) begin
        flag_d[i] = 1'b0;
      end
      if (deb_nxt[i*WIDTH +: WIDTH] != deb_cur[i*WIDTH +: WIDTH]) begin
        flag_d[i] = 1'b1;
      end
    end
  end

  // Synchroniser, LED and flag registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q   <= '0;
      s2_q   <= '0;
      led_q  <= '0;
      flag_q <= '0;
    end else begin
      s1_q   <= swIn;
      s2_q   <= s1_q;
      led_q  <= led_d;
      flag_q <= flag_d;
    end
  end

  // Zero-wait-state read mux; returns pre-edge register contents.
  always_comb begin
    rdData = 16'h0000;
    if (rd_en) begin
      if (hit_flag) begin
        rdData = 16'(flag_q);
      end else begin
        for (int i = 0; i < int'(NUM_CH); i++) begin
          if (offset == 16'(i)) rdData = 16'(deb_cur[i*WIDTH +: WIDTH]);
        end
      end
    end
  end

  assign drive_L = !rd_en;
  assign ledOut  = led_q;
  assign chgIrq  = |flag_q;

endmodule

// File: tb/tb_mmio_port_bank.sv
// Directed bench for mmio_port_bank at NUM_CH=4, WIDTH=16, BASE_ADDR=2000, DEB_CYC=4.
module tb_mmio_port_bank;

`ifdef MMIO_DEBOUNCE_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 2;
`endif

  logic        clock;
  logic        reset;
  logic [15:0] memAddr;
  logic        re_L;
  logic        we_L;
  logic [15:0] wrData;
  logic [15:0] rdData;
  logic        drive_L;
  logic [63:0] swIn;
  logic [63:0] ledOut;
  logic        chgIrq;

  int total;
  int bad;

  mmio_port_bank #(
    .NUM_CH(4), .WIDTH(16), .BASE_ADDR(16'h2000), .DEB_CYC(4)
  ) dut (
    .clock(clock), .reset(reset), .memAddr(memAddr), .re_L(re_L), .we_L(we_L),
    .wrData(wrData), .rdData(rdData), .drive_L(drive_L), .swIn(swIn),
    .ledOut(ledOut), .chgIrq(chgIrq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic rd(input logic [15:0] a);
    memAddr = a;
    re_L    = 1'b0;
    we_L    = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    logic [15:0] a;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a = 16'h2000 + 16'(i);
      rd(a);
      total++;
      if (rdData !== 16'h0000 || drive_L !== 1'b0) begin
        bad++;
        $display("FAIL reset_rd_%h: rdData=%h drive_L=%b expected 0000/0", a, rdData, drive_L);
      end
    end
    rd(16'h2005);
    total++;
    if (rdData !== 16'h0000 || drive_L !== 1'b1) begin
      bad++;
      $display("FAIL reset_rd_2005: rdData=%h drive_L=%b expected 0000/1", rdData, drive_L);
    end
    total++;
    if (ledOut !== 64'h0 || chgIrq !== 1'b0) begin
      bad++;
      $display("FAIL reset_out: ledOut=%h chgIrq=%b expected 0/0", ledOut, chgIrq);
    end
    re_L = 1'b1;
  endtask

  task automatic test_write();
    memAddr = 16'h2002;
    wrData  = 16'hBEEF;
    we_L    = 1'b0;
    tick();
    we_L = 1'b1;
    total++;
    if (ledOut !== 64'h0000_BEEF_0000_0000) begin
      bad++;
      $display("FAIL write_led: ledOut=%h expected 0000beef00000000", ledOut);
    end
    memAddr = 16'h2007;
    wrData  = 16'h1234;
    we_L    = 1'b0;
    tick();
    we_L = 1'b1;
    total++;
    if (ledOut !== 64'h0000_BEEF_0000_0000 || chgIrq !== 1'b0) begin
      bad++;
      $display("FAIL write_oob: ledOut=%h chgIrq=%b expected 0000beef00000000/0", ledOut, chgIrq);
    end
  endtask

  task automatic test_input_sync();
    logic [15:0] exp_rd;
    logic        exp_irq;
    swIn[31:16] = 16'h00A5;
    rd(16'h2001);
    for (int e = 1; e <= LAT; e++) begin
      tick();
      exp_rd  = (e == LAT) ? 16'h00A5 : 16'h0000;
      exp_irq = (e == LAT);
      total++;
      if (rdData !== exp_rd || chgIrq !== exp_irq) begin
        bad++;
        $display("FAIL sync_edge%0d: rdData=%h chgIrq=%b expected %h/%b",
                 e, rdData, chgIrq, exp_rd, exp_irq);
      end
    end
    rd(16'h2004);
    total++;
    if (rdData !== 16'h0002) begin
      bad++;
      $display("FAIL sync_flags: flags=%h expected 0002", rdData);
    end
    re_L = 1'b1;
  endtask

`ifdef MMIO_DEBOUNCE_EN
  task automatic test_debounce();
    swIn[0] = 1'b1;
    tick(); tick(); tick();
    swIn[0] = 1'b0;
    repeat (8) tick();
    rd(16'h2000);
    total++;
    if (rdData !== 16'h0000) begin
      bad++;
      $display("FAIL deb_glitch_rd: rdData=%h expected 0000", rdData);
    end
    rd(16'h2004);
    total++;
    if (rdData !== 16'h0002) begin
      bad++;
      $display("FAIL deb_glitch_flag: flags=%h expected 0002", rdData);
    end
    swIn[0] = 1'b1;
    rd(16'h2000);
    for (int e = 1; e <= 6; e++) begin
      tick();
      if (e == 4) swIn[0] = 1'b0;
    end
    total++;
    if (rdData !== 16'h0001) begin
      bad++;
      $display("FAIL deb_held_rd: rdData=%h expected 0001", rdData);
    end
    rd(16'h2004);
    total++;
    if (rdData !== 16'h0003) begin
      bad++;
      $display("FAIL deb_held_flag: flags=%h expected 0003", rdData);
    end
    re_L = 1'b1;
    repeat (10) tick();
  endtask
`endif

  task automatic test_w1c_collision();
    swIn[15:0] = 16'h0001;
    repeat (LAT) tick();
    rd(16'h2004);
    total++;
    if (rdData !== 16'h0003) begin
      bad++;
      $display("FAIL w1c_pre: flags=%h expected 0003", rdData);
    end
    re_L = 1'b1;
    swIn[15:0] = 16'h0000;
    repeat (LAT - 1) tick();
    memAddr = 16'h2004;
    wrData  = 16'h0003;
    re_L    = 1'b0;
    we_L    = 1'b0;
    #1;
    total++;
    if (rdData !== 16'h0003 || drive_L !== 1'b0) begin
      bad++;
      $display("FAIL w1c_rdwr_pre: rdData=%h drive_L=%b expected 0003/0", rdData, drive_L);
    end
    tick();
    we_L = 1'b1;
    #1;
    total++;
    if (rdData !== 16'h0001 || chgIrq !== 1'b1) begin
      bad++;
      $display("FAIL w1c_setwins: flags=%h chgIrq=%b expected 0001/1", rdData, chgIrq);
    end
    rd(16'h2000);
    total++;
    if (rdData !== 16'h0000) begin
      bad++;
      $display("FAIL w1c_ch0: rdData=%h expected 0000", rdData);
    end
    re_L    = 1'b1;
    memAddr = 16'h2004;
    wrData  = 16'h0001;
    we_L    = 1'b0;
    tick();
    we_L = 1'b1;
    rd(16'h2004);
    total++;
    if (rdData !== 16'h0000 || chgIrq !== 1'b0) begin
      bad++;
      $display("FAIL w1c_clear: flags=%h chgIrq=%b expected 0000/0", rdData, chgIrq);
    end
    re_L = 1'b1;
  endtask

  task automatic test_reset_mid();
    logic exp_irq;
    swIn[63:48] = 16'h0001;
    repeat (LAT) tick();
    rd(16'h2004);
    total++;
    if (rdData !== 16'h0008) begin
      bad++;
      $display("FAIL rmid_pre: flags=%h expected 0008", rdData);
    end
    re_L = 1'b1;
    swIn[63:48] = 16'h0003;
    repeat (LAT - 2) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if (ledOut !== 64'h0 || chgIrq !== 1'b0) begin
      bad++;
      $display("FAIL rmid_clear: ledOut=%h chgIrq=%b expected 0/0", ledOut, chgIrq);
    end
    rd(16'h2001);
    total++;
    if (rdData !== 16'h0000) begin
      bad++;
      $display("FAIL rmid_ch1: rdData=%h expected 0000", rdData);
    end
    re_L = 1'b1;
    for (int e = 1; e <= LAT; e++) begin
      tick();
      exp_irq = (e == LAT);
      total++;
      if (chgIrq !== exp_irq) begin
        bad++;
        $display("FAIL rmid_edge%0d: chgIrq=%b expected %b", e, chgIrq, exp_irq);
      end
    end
    rd(16'h2004);
    total++;
    if (rdData !== 16'h000A) begin
      bad++;
      $display("FAIL rmid_flags: flags=%h expected 000a", rdData);
    end
    rd(16'h2003);
    total++;
    if (rdData !== 16'h0003) begin
      bad++;
      $display("FAIL rmid_ch3: rdData=%h expected 0003", rdData);
    end
    re_L = 1'b1;
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    reset   = 1'b1;
    memAddr = 16'h0000;
    re_L    = 1'b1;
    we_L    = 1'b1;
    wrData  = 16'h0000;
    swIn    = 64'h0;
    test_reset();
    test_write();
    test_input_sync();
`ifdef MMIO_DEBOUNCE_EN
    test_debounce();
`endif
    test_w1c_collision();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
